// File: rtl/audio_mixer_pkg.sv
// Shared types, register map and helpers for the audio_mixer block.
// Volume scaling is compiled in only when AUDIO_MIXER_VOLUME_EN is defined.
package audio_mixer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACC   = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_IRQ_STAT = 5'd1;
    localparam logic [4:0] REG_VOL_BASE = 5'd2;
    localparam logic [4:0] REG_END_BASE = 5'd10;

    localparam int LOOP_LSB    = 8;
    localparam int IRQ_OVR_BIT = 8;

    function automatic int unity_vol(input int vol_w);
        return 32'sd1 << (vol_w - 32'sd1);
    endfunction

endpackage

// File: rtl/audio_mixer_regs.sv
// Host register file: CTRL, IRQ_STAT (write-1-to-clear), END[ch] and, when
// AUDIO_MIXER_VOLUME_EN is defined, VOL[ch].
module audio_mixer_regs
    import audio_mixer_pkg::*;
#(
    parameter int NUM_CH = 4,
`ifdef AUDIO_MIXER_VOLUME_EN
    parameter int VOL_W  = 8,
`endif
    parameter int ADDR_W = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wr_en,
    input  logic [4:0]                    address,
    input  logic [15:0]                   writedata,
    input  logic [NUM_CH-1:0]             done_set,
    input  logic                          overrun_set,
    output logic [NUM_CH-1:0]             play,
    output logic [NUM_CH-1:0]             loop,
    output logic [NUM_CH-1:0]             play_rise,
`ifdef AUDIO_MIXER_VOLUME_EN
    output logic [NUM_CH-1:0][VOL_W-1:0]  vol,
`endif
    output logic [NUM_CH-1:0][ADDR_W-1:0] end_addr,
    output logic                          irq
);

    logic [NUM_CH-1:0]             play_r;
    logic [NUM_CH-1:0]             loop_r;
    logic [NUM_CH-1:0]             done_r;
    logic                          ovr_r;
    logic                          irq_r;
    logic [NUM_CH-1:0][ADDR_W-1:0] end_r;
`ifdef AUDIO_MIXER_VOLUME_EN
    logic [NUM_CH-1:0][VOL_W-1:0]  vol_r;
`endif

    logic                          ctrl_wr_s;
    logic                          stat_wr_s;
    logic [NUM_CH-1:0]             play_next_s;
    logic [NUM_CH-1:0]             done_next_s;
    logic                          ovr_next_s;

    // Next-state decode: a host CTRL write overrides an end-of-sample clear,
    // and a status set overrides a simultaneous write-1-to-clear.
    always_comb begin
        ctrl_wr_s   = wr_en && (address == REG_CTRL);
        stat_wr_s   = wr_en && (address == REG_IRQ_STAT);
        play_next_s = ctrl_wr_s ? writedata[NUM_CH-1:0] : (play_r & ~done_set);
        play_rise_s_calc();
        done_next_s = (done_r & ~(stat_wr_s ? writedata[NUM_CH-1:0] : {NUM_CH{1'b0}})) | done_set;
        ovr_next_s  = (ovr_r & ~(stat_wr_s & writedata[IRQ_OVR_BIT])) | overrun_set;
    end

    function automatic void play_rise_s_calc();
        play_rise = ctrl_wr_s ? (writedata[NUM_CH-1:0] & ~play_r) : {NUM_CH{1'b0}};
    endfunction

    // Register storage; irq tracks the OR of the status bits it is loaded with.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            play_r <= {NUM_CH{1'b0}};
            loop_r <= {NUM_CH{1'b0}};
            done_r <= {NUM_CH{1'b0}};
            ovr_r  <= 1'b0;
            irq_r  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                end_r[i] <= {ADDR_W{1'b0}};
`ifdef AUDIO_MIXER_VOLUME_EN
                vol_r[i] <= VOL_W'(unity_vol(VOL_W));
`endif
            end
        end else begin
            play_r <= play_next_s;
            done_r <= done_next_s;
            ovr_r  <= ovr_next_s;
            irq_r  <= (|done_next_s) | ovr_next_s;
            if (ctrl_wr_s) begin
                loop_r <= writedata[LOOP_LSB +: NUM_CH];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en && (address == REG_END_BASE + 5'(i))) begin
                    end_r[i] <= ADDR_W'(writedata);
                end
`ifdef AUDIO_MIXER_VOLUME_EN
                if (wr_en && (address == REG_VOL_BASE + 5'(i))) begin
                    vol_r[i] <= VOL_W'(writedata);
                end
`endif
            end
        end
    end

    assign play     = play_r;
    assign loop     = loop_r;
    assign end_addr = end_r;
    assign irq      = irq_r;
`ifdef AUDIO_MIXER_VOLUME_EN
    assign vol      = vol_r;
`endif

endmodule

// File: rtl/audio_mixer.sv
// Multi-channel sample mixer: fetches one ROM word per channel per codec request,
// scales (AUDIO_MIXER_VOLUME_EN), accumulates, saturates and presents the mix.
module audio_mixer
    import audio_mixer_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  SAMPLE_W = 16,
    parameter int  ADDR_W   = 16,
    parameter int  VOL_W    = 8,
    localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic [4:0]                 address,
    input  logic [15:0]                writedata,
    output logic                       irq,
    input  logic                       sample_req,
    output logic signed [SAMPLE_W-1:0] audio_output,
    output logic [SEL_W-1:0]           rom_sel,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic signed [SAMPLE_W-1:0] rom_data
);

    localparam int ACC_W = SAMPLE_W + VOL_W + $clog2(NUM_CH) + 1;

    state_e                        state_r;
    logic [SEL_W-1:0]              ch_r;
    logic signed [ACC_W-1:0]       acc_r;
    logic signed [SAMPLE_W-1:0]    sample_r;
    logic [ADDR_W-1:0]             ptr_r      [NUM_CH];
    logic [ADDR_W-1:0]             ptr_next_s [NUM_CH];

    logic [NUM_CH-1:0]             play_s;
    logic [NUM_CH-1:0]             loop_s;
    logic [NUM_CH-1:0]             play_rise_s;
    logic [NUM_CH-1:0]             done_s;
    logic [NUM_CH-1:0][ADDR_W-1:0] end_s;
    logic                          wr_en_s;
    logic                          overrun_s;
    logic                          last_ch_s;
    logic                          cur_play_s;
    logic [SEL_W-1:0]              next_ch_s;
    logic signed [ACC_W-1:0]       scaled_s;
    logic signed [SAMPLE_W-1:0]    sat_s;
    logic [ACC_W-SAMPLE_W:0]       acc_hi_s;
`ifdef AUDIO_MIXER_VOLUME_EN
    localparam int PROD_W = SAMPLE_W + VOL_W + 1;
    logic [NUM_CH-1:0][VOL_W-1:0]  vol_s;
    logic signed [PROD_W-1:0]      prod_s;
`endif

    assign wr_en_s   = chipselect && write;
    assign overrun_s = sample_req && (state_r != ST_IDLE);

    audio_mixer_regs #(
        .NUM_CH (NUM_CH),
`ifdef AUDIO_MIXER_VOLUME_EN
        .VOL_W  (VOL_W),
`endif
        .ADDR_W (ADDR_W)
    ) u_regs (
        .clk         (clk),
        .resetn      (resetn),
        .wr_en       (wr_en_s),
        .address     (address),
        .writedata   (writedata),
        .done_set    (done_s),
        .overrun_set (overrun_s),
        .play        (play_s),
        .loop        (loop_s),
        .play_rise   (play_rise_s),
`ifdef AUDIO_MIXER_VOLUME_EN
        .vol         (vol_s),
`endif
        .end_addr    (end_s),
        .irq         (irq)
    );

    // Per-channel contribution and output saturation.
    always_comb begin
        cur_play_s = play_s[ch_r];
        last_ch_s  = (ch_r == SEL_W'(NUM_CH - 1));
        next_ch_s  = ch_r + SEL_W'(1'b1);
`ifdef AUDIO_MIXER_VOLUME_EN
        prod_s     = PROD_W'(sample_r) * $signed(PROD_W'(vol_s[ch_r]));
        scaled_s   = ACC_W'(prod_s >>> (VOL_W - 1));
`else
        scaled_s   = ACC_W'(sample_r);
`endif
        acc_hi_s   = acc_r[ACC_W-1:SAMPLE_W-1];
        if ((&acc_hi_s) || !(|acc_hi_s)) begin
            sat_s = acc_r[SAMPLE_W-1:0];
        end else if (acc_r[ACC_W-1]) begin
            sat_s = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            sat_s = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    end

    // Read-pointer advance; a host play 0->1 rewinds the channel to address 0.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ptr_next_s[i] = ptr_r[i];
            done_s[i]     = 1'b0;
            if (play_rise_s[i]) begin
                ptr_next_s[i] = {ADDR_W{1'b0}};
            end else if ((state_r == ST_ACC) && (ch_r == SEL_W'(i)) && play_s[i]) begin
                if (ptr_r[i] != end_s[i]) begin
                    ptr_next_s[i] = ptr_r[i] + ADDR_W'(1'b1);
                end else if (loop_s[i]) begin
                    ptr_next_s[i] = {ADDR_W{1'b0}};
                end else begin
                    done_s[i] = 1'b1;
                end
            end else begin
                ptr_next_s[i] = ptr_r[i];
            end
        end
    end

    // Pointer storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ptr_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ptr_r[i] <= ptr_next_s[i];
            end
        end
    end

    // Mix sequencer; ROM select/address are loaded on entry to FETCH and held otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            ch_r         <= {SEL_W{1'b0}};
            acc_r        <= {ACC_W{1'b0}};
            sample_r     <= {SAMPLE_W{1'b0}};
            audio_output <= {SAMPLE_W{1'b0}};
            rom_sel      <= {SEL_W{1'b0}};
            rom_addr     <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sample_req) begin
                        acc_r    <= {ACC_W{1'b0}};
                        ch_r     <= {SEL_W{1'b0}};
                        rom_sel  <= {SEL_W{1'b0}};
                        rom_addr <= ptr_next_s[0];
                        state_r  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    sample_r <= rom_data;
                    state_r  <= ST_ACC;
                end
                ST_ACC: begin
                    if (cur_play_s) begin
                        acc_r <= acc_r + scaled_s;
                    end
                    if (last_ch_s) begin
                        state_r <= ST_OUT;
                    end else begin
                        ch_r     <= next_ch_s;
                        rom_sel  <= next_ch_s;
                        rom_addr <= ptr_next_s[next_ch_s];
                        state_r  <= ST_FETCH;
                    end
                end
                ST_OUT: begin
                    audio_output <= sat_s;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer: table-driven mix vectors plus hand-built
// multi-cycle sequences, with expected samples queued at request time.
module tb_audio_mixer;

    localparam int NUM_CH = 4;
    localparam int LAT    = 3 * NUM_CH + 2;

`ifdef AUDIO_MIXER_VOLUME_EN
    localparam logic [15:0] VOL_EXP   = 16'd500;
    localparam logic [15:0] HALF_EXP  = 16'd6;
`else
    localparam logic [15:0] VOL_EXP   = 16'd1000;
    localparam logic [15:0] HALF_EXP  = 16'd11;
`endif

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               chipselect = 1'b0;
    logic               write = 1'b0;
    logic [4:0]         address = 5'd0;
    logic [15:0]        writedata = 16'd0;
    logic               irq;
    logic               sample_req = 1'b0;
    logic signed [15:0] audio_output;
    logic [1:0]         rom_sel;
    logic [15:0]        rom_addr;
    logic signed [15:0] rom_data = 16'sd0;

    logic [15:0] rom_mem [4][16];
    logic [15:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  play;
        logic [15:0] s0, s1, s2, s3;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [14];

    audio_mixer dut (
        .clk          (clk),
        .resetn       (resetn),
        .chipselect   (chipselect),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .irq          (irq),
        .sample_req   (sample_req),
        .audio_output (audio_output),
        .rom_sel      (rom_sel),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after select/address.
    always @(posedge clk) rom_data <= rom_mem[rom_sel][rom_addr[3:0]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h required 0x%04h", name, got, exp);
        end
    endtask

    task automatic pop_check(input string name);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got 0x%04h required queued sample (queue empty)", name, audio_output);
        end else begin
            e = exp_q.pop_front();
            check(name, audio_output, e);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    // One full frame; output checked on the first cycle it is due.
    task automatic frame(input logic [15:0] exp, input string name);
        exp_q.push_back(exp);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        repeat (LAT - 1) tick();
        pop_check(name);
    endtask

    // Frame with a host write landing in the ch0 accumulate cycle.
    task automatic frame_with_write(input logic [15:0] exp, input logic [4:0] a,
                                    input logic [15:0] d, input string name);
        exp_q.push_back(exp);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        tick();
        bus_write(a, d);
        repeat (LAT - 4) tick();
        pop_check(name);
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd1000};
        vecs[1]  = '{4'b0011, 16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd3000};
        vecs[2]  = '{4'b1111, 16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd10000};
        vecs[3]  = '{4'b0000, 16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd0};
        vecs[4]  = '{4'b1010, 16'd1, 16'hFFFB, 16'd7, 16'hFFF7, 16'hFFF2};
        vecs[5]  = '{4'b0011, 16'h7000, 16'h7000, 16'd0, 16'd0, 16'h7FFF};
        vecs[6]  = '{4'b0011, 16'h9000, 16'h9000, 16'd0, 16'd0, 16'h8000};
        vecs[7]  = '{4'b1111, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[8]  = '{4'b1111, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        vecs[9]  = '{4'b0101, 16'h4000, 16'h007B, 16'h3FFF, 16'd0, 16'h7FFF};
        vecs[10] = '{4'b0101, 16'hC000, 16'd0, 16'hBFFF, 16'd0, 16'h8000};
        vecs[11] = '{4'b0110, 16'd0, 16'h8000, 16'h0001, 16'd0, 16'h8001};
        vecs[12] = '{4'b1100, 16'd0, 16'd0, 16'h7FFF, 16'h0001, 16'h7FFF};
        vecs[13] = '{4'b1001, 16'h8000, 16'd0, 16'd0, 16'hFFFF, 16'h8000};

        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 16; a++)
                rom_mem[c][a] = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_audio_output", audio_output, 16'd0);
        check("reset_irq", {15'd0, irq}, 16'd0);
        check("reset_rom_sel", {14'd0, rom_sel}, 16'd0);
        check("reset_rom_addr", rom_addr, 16'd0);
        resetn = 1'b1;
        tick();

        // Mix table: every channel loops on address 0.
        for (int v = 0; v < 14; v++) begin
            rom_mem[0][0] = vecs[v].s0;
            rom_mem[1][0] = vecs[v].s1;
            rom_mem[2][0] = vecs[v].s2;
            rom_mem[3][0] = vecs[v].s3;
            bus_write(5'd0, 16'h0000);
            bus_write(5'd0, {8'h0F, 4'h0, vecs[v].play});
            frame(vecs[v].exp, $sformatf("mix_vec%0d", v));
        end

        // Single looping channel.
        rom_mem[0][0] = 16'd100; rom_mem[0][1] = 16'd200;
        rom_mem[0][2] = 16'd300; rom_mem[0][3] = 16'd400;
        bus_write(5'd10, 16'd3);
        bus_write(5'd0, 16'h0000);
        bus_write(5'd0, 16'h0101);
        for (int n = 0; n < 8; n++)
            frame(16'd100 * 16'(n % 4 + 1), $sformatf("loop_frame%0d", n));
        check("loop_irq", {15'd0, irq}, 16'd0);

        // One-shot end of sample.
        rom_mem[0][0] = 16'd111; rom_mem[0][1] = 16'hFF22;
        bus_write(5'd10, 16'd1);
        bus_write(5'd0, 16'h0000);
        bus_write(5'd0, 16'h0001);
        frame(16'd111, "oneshot_f0");
        frame(16'hFF22, "oneshot_f1");
        frame(16'd0, "oneshot_f2");
        check("oneshot_irq_set", {15'd0, irq}, 16'd1);
        bus_write(5'd1, 16'h0001);
        check("oneshot_irq_clr", {15'd0, irq}, 16'd0);

        // Host write racing the end-of-sample event.
        rom_mem[0][0] = 16'd321;
        bus_write(5'd10, 16'd0);
        bus_write(5'd0, 16'h0000);
        bus_write(5'd0, 16'h0001);
        frame_with_write(16'd321, 5'd0, 16'h0001, "race_ctrl_frame");
        check("race_ctrl_irq", {15'd0, irq}, 16'd1);
        frame_with_write(16'd321, 5'd1, 16'h0001, "race_play_kept");
        check("race_set_beats_clr", {15'd0, irq}, 16'd1);
        frame(16'd0, "race_play_cleared");
        bus_write(5'd1, 16'h0001);
        check("race_irq_clr", {15'd0, irq}, 16'd0);

        // Overrun: second request two cycles into the frame.
        bus_write(5'd0, 16'h0000);
        frame(16'd0, "ovr_pre");
        rom_mem[0][0] = 16'd555; rom_mem[0][1] = 16'd777;
        bus_write(5'd10, 16'd1);
        bus_write(5'd0, 16'h0101);
        exp_q.push_back(16'd555);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick();
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        repeat (LAT - 4) tick();
        check("ovr_not_early", audio_output, 16'd0);
        tick();
        pop_check("ovr_frame");
        check("ovr_irq", {15'd0, irq}, 16'd1);
        repeat (LAT) tick();
        check("ovr_single_update", audio_output, 16'd555);
        bus_write(5'd1, 16'h0100);
        check("ovr_irq_clr", {15'd0, irq}, 16'd0);
        frame(16'd777, "ovr_next_frame");

        // Volume scaling.
        rom_mem[0][0] = 16'd1000;
        bus_write(5'd10, 16'd0);
        bus_write(5'd0, 16'h0000);
        bus_write(5'd2, 16'd64);
        bus_write(5'd0, 16'h0101);
        frame(VOL_EXP, "volume_half");

        // Reset during ch1 WAIT.
        rom_mem[0][0] = 16'd10; rom_mem[0][1] = 16'd20; rom_mem[0][2] = 16'd30; rom_mem[0][3] = 16'd40;
        rom_mem[1][0] = 16'd1;  rom_mem[1][1] = 16'd2;  rom_mem[1][2] = 16'd3;  rom_mem[1][3] = 16'd4;
        bus_write(5'd10, 16'd3);
        bus_write(5'd11, 16'd3);
        bus_write(5'd0, 16'h0000);
        bus_write(5'd0, 16'h0303);
        frame(HALF_EXP, "rst_pre_frame");
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        repeat (4) tick();
        resetn = 1'b0;
        #1;
        check("rst_mid_audio", audio_output, 16'd0);
        check("rst_mid_irq", {15'd0, irq}, 16'd0);
        check("rst_mid_rom_addr", rom_addr, 16'd0);
        tick();
        resetn = 1'b1;
        tick();
        bus_write(5'd10, 16'd3);
        bus_write(5'd11, 16'd3);
        bus_write(5'd0, 16'h0303);
        frame(16'd11, "rst_post_f0");
        frame(16'd22, "rst_post_f1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
